alu_io_stim: RTL and testbench
==============================

# alu_io_stim

Self-test stimulus generator and response compactor for the dual 4-bit ALU user macro. It is the driving end of the ALU's pad-level interface: it produces pseudo-random operand/select vectors on the 20 ALU input lines and samples the 15 ALU result lines. Each sampled result is folded into a 32-bit MISR signature and checked for internal consistency. Software controls and reads it as a Wishbone classic slave on the user-project bus.

## Interface
Parameters:
- RESP_LAT, default 2: cycles from a vector appearing on stim_o to sampling of the matching resp_i (range 1–8).
- SEED, default 20'h5A5A5: LFSR load value on start. Must be nonzero.

Ports:
- wb_clk_i, input, 1: single clock.
- wb_rst_ni, input, 1: reset, asynchronous and active-low.
- wbs_stb_i, input, 1: strobe.
- wbs_cyc_i, input, 1: bus cycle.
- wbs_we_i, input, 1: write enable.
- wbs_sel_i, input, 4: byte selects.
- wbs_dat_i, input, 32: write data.
- wbs_adr_i, input, 32: address; only bits [3:2] decoded.
- wbs_ack_o, output, 1: acknowledge.
- wbs_dat_o, output, 32: read data.
- stim_o, output, 20: ALU inputs, packed as {Sel2[1:0], Sel1[1:0], B1, A1, B0, A0}, with A0 at [3:0].
- resp_i, input, 15: ALU outputs, packed as {Out1[3:0], Out2[3:0], x[3:0], Carry1, Carry2, y}.
- busy_o, output, 1: high in RUN or DRAIN.
- done_o, output, 1: sticky run-complete flag.

## Operation
Register map (wbs_adr_i[3:2]):
- 0 CTRL
  - Write, effective only when sel[0]=1: bit0 = start, bit1 = abort.
  - Read: {30'b0, done, busy}.
- 1 COUNT: R/W, bits [15:0] give the number of vectors. Writes honor sel[1:0]. Reset value 0.
- 2 SIG: read-only, MISR value.
- 3 ERRS: read-only, {16'b0, err_cnt}. err_cnt saturates at 16'hFFFF.
- Writes to read-only registers are acked and ignored.

Wishbone behaviour:
- A request is stb & cyc & !ack.
- wbs_ack_o rises on the clock edge after a request is seen and stays high for exactly one cycle.
- wbs_dat_o is valid while ack is high and 0 otherwise.
- Register writes take effect on the same edge that raises ack.

State machine: IDLE, RUN, DRAIN.
- IDLE + start:
  - Clear done.
  - Load LFSR with SEED; clear MISR, err_cnt, and the vector counter.
  - Go to RUN. If COUNT=0, go to DRAIN instead.
- RUN:
  - Each cycle, stim_o = LFSR. The LFSR then advances: next = {lfsr[18:0], lfsr[19]^lfsr[16]}.
  - A 1 is pushed into a RESP_LAT-deep valid pipe.
  - After COUNT vectors have been issued, go to DRAIN.
- DRAIN:
  - stim_o = 0; 0s are pushed into the valid pipe.
  - After RESP_LAT cycles, go to IDLE and set done.
- Sampling: whenever the valid pipe output is 1, resp_i is sampled. The MISR updates as misr = {misr[30:0],1'b0} ^ (misr[31] ? 32'h04C11DB7 : 0) ^ {17'b0, resp_i}.
- Consistency error: x != Out1^Out2, or y != Carry1^Carry2. Each error increments err_cnt (saturating).
- Abort in RUN or DRAIN:
  - Go to IDLE on the next edge and flush the valid pipe.
  - done is not set; SIG and ERRS keep their partial values.
- Start while busy is ignored. Abort in IDLE is ignored. If start and abort are written together, abort wins.
- A COUNT write while busy updates the register but does not affect the current run.

## Timing
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0.
  - stim_o=0, busy_o=0, done_o=0.
  - SIG=0, ERRS=0, COUNT=0.
  - State IDLE; valid pipe all 0.
- Start written on edge E:
  - busy_o=1 and vector 0 appears on stim_o from E+1.
  - Vector k is present during cycle E+1+k.
  - Its response is sampled at edge E+1+k+RESP_LAT.
- Total run time: busy high for COUNT+RESP_LAT cycles, then done_o=1 on the following cycle.
- COUNT=0: busy for RESP_LAT cycles, then done with SIG=0 and ERRS=0.
- All outputs are registered; there is no combinational path from Wishbone inputs to stim_o.
- Reset assertion mid-run immediately forces all reset values.

## Test plan
- Reset, then read all four registers → 0, 0, 0, 0. ack is exactly one cycle wide per access; back-to-back stb held high gives ack every other cycle.
- COUNT=4, RESP_LAT=2, resp_i driven by a consistent ALU model, start → stim_o shows 20'h5A5A5 then three further LFSR steps; busy for 6 cycles; done=1; ERRS=0; SIG equals the golden MISR.
- COUNT=10, resp_i tied to 15'h0001 (y=1, carries 0) → ERRS=10; SIG equals the golden MISR of ten 15'h0001 samples.
- COUNT=100, abort written at vector 40 → busy drops the next cycle; done=0; ERRS/SIG reflect at most 40 samples; a second start runs to completion.
- Start written while busy, and a COUNT write with sel=4'b0001 → run unaffected; COUNT low byte updated, high byte preserved.
- wb_rst_ni pulsed low mid-DRAIN → all outputs return to reset values asynchronously; the next start behaves as from power-up.

Source files
------------

// File: rtl/alu_io_stim.sv
// alu_io_stim: self-test stimulus generator and response compactor for the
// dual 4-bit ALU macro, controlled over a Wishbone classic slave port.
//
// Ports:
//   wb_clk_i, wb_rst_ni       clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i      Wishbone request qualifiers
//   wbs_sel_i, wbs_dat_i      byte selects and write data
//   wbs_adr_i                 address, bits [3:2] select CTRL/COUNT/SIG/ERRS
//   wbs_ack_o, wbs_dat_o      one-cycle acknowledge and read data
//   stim_o                    {Sel2, Sel1, B1, A1, B0, A0} driven to the ALU
//   resp_i                    {Out1, Out2, x, Carry1, Carry2, y} from the ALU
//   busy_o, done_o            run in progress / sticky run-complete
module alu_io_stim #(
  parameter int unsigned RESP_LAT = 2,
  parameter logic [19:0] SEED     = 20'h5A5A5
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [19:0] stim_o,
  input  logic [14:0] resp_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] MISR_POLY  = 32'h04C11DB7;
  localparam logic [3:0]  DRAIN_LAST = 4'(RESP_LAT - 1);

  state_t              state;
  logic [19:0]         lfsr;
  logic [15:0]         count_reg;
  logic [15:0]         run_cnt;
  logic [15:0]         vec_cnt;
  logic [3:0]          drain_cnt;
  logic [31:0]         misr;
  logic [15:0]         err_cnt;
  logic [RESP_LAT-1:0] vld_p;
  logic [RESP_LAT:0]   vld_shift;
  logic                fin_p1;

  logic        req;
  logic        wr_req;
  logic [1:0]  adr;
  logic        ctrl_wr;
  logic        start;
  logic        abort;
  logic        push;
  logic        sample;
  logic [31:0] rd_data;
  logic        unused_ok;

  function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [14:0] d);
    return {m[30:0], 1'b0} ^ (m[31] ? MISR_POLY : 32'h0) ^ {17'b0, d};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    if (en && (c != 16'hFFFF))
      return c + 16'd1;
    return c;
  endfunction

  // x must equal Out1^Out2 and y must equal Carry1^Carry2
  function automatic logic resp_err(input logic [14:0] r);
    return (r[6:3] != (r[14:11] ^ r[10:7])) || (r[0] != (r[2] ^ r[1]));
  endfunction

  assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr_req  = req & wbs_we_i;
  assign adr     = wbs_adr_i[3:2];
  assign ctrl_wr = wr_req && (adr == 2'd0) && wbs_sel_i[0];
  // Abort has priority: a start with the abort bit set never launches a run
  assign start   = ctrl_wr && wbs_dat_i[0] && !wbs_dat_i[1] && (state == ST_IDLE);
  assign abort   = ctrl_wr && wbs_dat_i[1] && (state != ST_IDLE);
  assign push    = (state == ST_RUN) && !abort;
  assign sample  = vld_p[RESP_LAT-1] && !abort;

  assign vld_shift = {vld_p, push};
  assign unused_ok = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  always_comb begin
    rd_data = 32'h0;
    case (adr)
      2'd0:    rd_data = {30'b0, done_o, busy_o};
      2'd1:    rd_data = {16'b0, count_reg};
      2'd2:    rd_data = misr;
      default: rd_data = {16'b0, err_cnt};
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      stim_o    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      state     <= ST_IDLE;
      lfsr      <= '0;
      count_reg <= '0;
      run_cnt   <= '0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
      misr      <= '0;
      err_cnt   <= '0;
      vld_p     <= '0;
      fin_p1    <= 1'b0;
    end else begin
      // bus stage: ack and read data one edge after the request
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rd_data : 32'h0;
      if (wr_req && (adr == 2'd1)) begin
        if (wbs_sel_i[0]) count_reg[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) count_reg[15:8] <= wbs_dat_i[15:8];
      end

      // p0: vector launch, valid enters the response pipe with it
      stim_o <= push ? lfsr : 20'h0;
      vld_p  <= abort ? '0 : vld_shift[RESP_LAT-1:0];
      busy_o <= (state != ST_IDLE);
      fin_p1 <= (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST) && !abort;
      if (fin_p1)
        done_o <= 1'b1;

      // p(RESP_LAT): response capture into the signature
      if (sample) begin
        misr    <= misr_step(misr, resp_i);
        err_cnt <= sat_inc(err_cnt, resp_err(resp_i));
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            done_o    <= 1'b0;
            lfsr      <= SEED;
            misr      <= '0;
            err_cnt   <= '0;
            vec_cnt   <= '0;
            drain_cnt <= '0;
            run_cnt   <= count_reg;
            state     <= (count_reg == 16'd0) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            lfsr    <= {lfsr[18:0], lfsr[19] ^ lfsr[16]};
            vec_cnt <= vec_cnt + 16'd1;
            if (vec_cnt == run_cnt - 16'd1)
              state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (abort || (drain_cnt == DRAIN_LAST))
            state <= ST_IDLE;
          else
            drain_cnt <= drain_cnt + 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_io_stim.sv
// Directed bench for alu_io_stim with a timeline model of the run and an
// ALU response model; outputs are compared every cycle against the model.
module tb_alu_io_stim;
  localparam int          RL   = 2;
  localparam logic [19:0] SEED = 20'h5A5A5;
  localparam int          NVEC = 300;
  localparam int          NONE = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_i = 32'h0, adr = 32'h0;
  logic        ack;
  logic [31:0] dat_o;
  logic [19:0] stim;
  logic [14:0] resp = 15'h0;
  logic        busy, done;

  always #5 clk = ~clk;

  alu_io_stim #(.RESP_LAT(RL), .SEED(SEED)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .stim_o(stim), .resp_i(resp), .busy_o(busy), .done_o(done)
  );

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // ---------------- reference models ----------------
  logic [19:0] vec [0:NVEC-1];
  initial begin
    logic [19:0] v;
    v = SEED;
    for (int k = 0; k < NVEC; k++) begin
      vec[k] = v;
      v = {v[18:0], v[19] ^ v[16]};
    end
  end

  function automatic logic [4:0] alu_unit(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  function automatic logic [14:0] alu_resp(input logic [19:0] s);
    logic [4:0] u1, u2;
    u1 = alu_unit(s[3:0], s[7:4], s[17:16]);
    u2 = alu_unit(s[11:8], s[15:12], s[19:18]);
    return {u1[3:0], u2[3:0], u1[3:0] ^ u2[3:0], u1[4], u2[4], u1[4] ^ u2[4]};
  endfunction

  int resp_mode = 0;  // 0: well-behaved ALU, 1: stuck at 15'h0001
  logic [19:0] hist [0:7];
  // ALU with RL-cycle latency back to the sampler
  always @(negedge clk) begin
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = stim;
    resp = (resp_mode != 0) ? 15'h0001 : alu_resp(hist[RL-1]);
  end

  function automatic logic [31:0] exp_sig(input int ns, input int mode);
    logic [31:0] m;
    logic [14:0] d;
    m = 32'h0;
    for (int k = 0; k < ns; k++) begin
      d = (mode != 0) ? 15'h0001 : alu_resp(vec[k]);
      m = (m << 1) ^ (m[31] ? 32'h04C11DB7 : 32'h0) ^ {17'b0, d};
    end
    return m;
  endfunction

  // run timeline: start written at edge e_start, optional abort at edge a_edge
  int   run_valid = 0;
  int   e_start = 0;
  int   r_cnt = 0;
  int   a_edge = NONE;
  logic done_prev = 1'b0;

  function automatic void exp_out(input int n, output logic b, output logic [19:0] s, output logic d);
    int rel;
    b = 1'b0; s = 20'h0; d = done_prev;
    if (run_valid != 0 && n >= e_start) begin
      rel = n - e_start;
      b = (rel >= 1) && (rel <= r_cnt + RL) && (n <= a_edge);
      s = ((rel >= 1) && (rel <= r_cnt) && (n < a_edge)) ? vec[rel-1] : 20'h0;
      d = (a_edge == NONE) && (rel >= r_cnt + RL + 1);
    end
  endfunction

  logic        eb, ed;
  logic [19:0] es;
  logic        chk_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      exp_out(cyc_n, eb, es, ed);
      check("busy_o", busy, eb);
      check("stim_o", stim, es);
      check("done_o", done, ed);
      if (!ack) check("dat_idle", dat_o, 32'h0);
    end
  end

  // ---------------- bus tasks (entered and left on a negedge) ----------------
  task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rd);
    stb = 1'b1; cyc = 1'b1; we = w; adr = {28'b0, a, 2'b00}; sel = s; dat_i = d;
    @(posedge clk); #1;
    check("ack_rise", ack, 1);
    rd = dat_o;
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_width", ack, 0);
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(1'b1, a, s, d, rd);
  endtask

  task automatic wb_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    wb_xfer(1'b0, a, 4'hF, 32'h0, rd);
    check(name, rd, exp);
  endtask

  task automatic start_run(input int cnt);
    logic b; logic [19:0] s; logic d;
    exp_out(cyc_n, b, s, d);
    done_prev = d;
    run_valid = 1; e_start = cyc_n + 1; r_cnt = cnt; a_edge = NONE;
    wb_write(2'd0, 4'hF, 32'h1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int ns;
    repeat (3) @(negedge clk);
    check("rst_stim", stim, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack", ack, 0);
    check("rst_dat", dat_o, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // model pinned by hand-derived values
    check("model_vec0", vec[0], 20'h5A5A5);
    check("model_vec1", vec[1], 20'hB4B4B);
    check("model_vec2", vec[2], 20'h69696);
    check("model_vec3", vec[3], 20'hD2D2C);
    check("model_sig_const10", exp_sig(10, 1), 32'h000003FF);

    @(negedge clk);
    wb_read(2'd0, 32'h0, "rd_ctrl_rst");
    wb_read(2'd1, 32'h0, "rd_count_rst");
    wb_read(2'd2, 32'h0, "rd_sig_rst");
    wb_read(2'd3, 32'h0, "rd_errs_rst");

    // strobe held high: ack on every other edge
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("ack_b2b", ack, (i % 2 == 0) ? 1 : 0);
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);

    // run of 4 with a consistent ALU
    resp_mode = 0;
    wb_write(2'd1, 4'hF, 32'd4);
    start_run(4);
    wait_done(40, "done_run4");
    wb_read(2'd2, exp_sig(4, 0), "sig_run4");
    wb_read(2'd3, 32'h0, "errs_run4");
    wb_read(2'd0, 32'h2, "ctrl_run4");

    // ten inconsistent samples
    resp_mode = 1;
    wb_write(2'd1, 4'hF, 32'd10);
    start_run(10);
    wait_done(60, "done_run10");
    wb_read(2'd2, 32'h000003FF, "sig_run10_lit");
    wb_read(2'd2, exp_sig(10, 1), "sig_run10");
    wb_read(2'd3, 32'd10, "errs_run10");

    // abort when vector 40 would appear, then a clean rerun
    resp_mode = 0;
    wb_write(2'd1, 4'hF, 32'd100);
    start_run(100);
    e = e_start;
    while (cyc_n < e + 40) @(negedge clk);
    a_edge = cyc_n + 1;
    wb_write(2'd0, 4'h1, 32'h2);
    check("done_after_abort", done, 0);
    ns = a_edge - e - 1 - RL;
    wb_read(2'd2, exp_sig(ns, 0), "sig_abort");
    wb_read(2'd3, 32'h0, "errs_abort");
    wb_write(2'd1, 4'hF, 32'd5);
    start_run(5);
    wait_done(40, "done_rerun");
    wb_read(2'd2, exp_sig(5, 0), "sig_rerun");

    // ignored controls in IDLE
    wb_write(2'd0, 4'hF, 32'h3);
    wb_write(2'd0, 4'hF, 32'h2);
    wb_write(2'd0, 4'hE, 32'h1);
    repeat (3) @(negedge clk);
    wb_read(2'd0, 32'h2, "ctrl_ignored");

    // start and partial COUNT write while busy
    wb_write(2'd1, 4'hF, 32'h0000_0105);
    start_run(261);
    repeat (3) @(negedge clk);
    wb_write(2'd0, 4'hF, 32'h1);
    wb_write(2'd1, 4'b0001, 32'hFFFF_FF07);
    wb_read(2'd1, 32'h0000_0107, "count_sel0");
    wait_done(400, "done_run261");
    wb_read(2'd2, exp_sig(261, 0), "sig_run261");
    wb_read(2'd3, 32'h0, "errs_run261");

    // asynchronous reset during DRAIN
    wb_write(2'd1, 4'hF, 32'd3);
    start_run(3);
    e = e_start;
    while (cyc_n < e + 4) @(negedge clk);
    check("busy_before_rst", busy, 1);
    #2;
    rst_n = 1'b0;
    run_valid = 0;
    done_prev = 1'b0;
    #1;
    check("arst_stim", stim, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ack", ack, 0);
    check("arst_dat", dat_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb_read(2'd0, 32'h0, "ctrl_post_rst");
    wb_read(2'd1, 32'h0, "count_post_rst");
    wb_read(2'd2, 32'h0, "sig_post_rst");
    wb_read(2'd3, 32'h0, "errs_post_rst");
    wb_write(2'd1, 4'hF, 32'd4);
    start_run(4);
    wait_done(40, "done_post_rst");
    wb_read(2'd2, exp_sig(4, 0), "sig_post_rst_run");
    wb_read(2'd3, 32'h0, "errs_post_rst_run");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
